// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator datapath:
// widths, opcodes and read-pending target encoding.
package acc_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 8;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_STA = 4'hA;
   localparam logic [3:0] OP_JMP = 4'hB;
   localparam logic [3:0] OP_JZ  = 4'hC;
   localparam logic [3:0] OP_JC  = 4'hD;
   localparam logic [3:0] OP_ILL = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [1:0] {
      PEND_NONE = 2'd0,
      PEND_MDR  = 2'd1,
      PEND_OPR  = 2'd2
   } pend_t;

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU: opcode, ACC and operand in;
// result, carry and write/side-effect qualifiers out.
module acc_alu #(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] opnd,
   output logic [DATA_W-1:0] res,
   output logic              c,
   output logic              z,
   output logic              wr_acc,
   output logic              wr_c,
   output logic              halt,
   output logic              illegal
);
   import acc_pkg::*;

   always_comb begin
      res     = acc;
      c       = 1'b0;
      wr_acc  = 1'b0;
      wr_c    = 1'b0;
      halt    = 1'b0;
      illegal = 1'b0;
      unique case (op)
         OP_LDA: begin
            res    = opnd;
            wr_acc = 1'b1;
         end
         OP_ADD: begin
            {c, res} = {1'b0, acc} + {1'b0, opnd};
            wr_acc   = 1'b1;
            wr_c     = 1'b1;
         end
         OP_SUB: begin
            res    = acc - opnd;
            c      = acc < opnd;
            wr_acc = 1'b1;
            wr_c   = 1'b1;
         end
         OP_AND: begin
            res    = acc & opnd;
            wr_acc = 1'b1;
         end
         OP_OR: begin
            res    = acc | opnd;
            wr_acc = 1'b1;
         end
         OP_XOR: begin
            res    = acc ^ opnd;
            wr_acc = 1'b1;
         end
         OP_NOT: begin
            res    = ~acc;
            wr_acc = 1'b1;
         end
         OP_SHL: begin
            c      = acc[DATA_W-1];
            res    = {acc[DATA_W-2:0], 1'b0};
            wr_acc = 1'b1;
            wr_c   = 1'b1;
         end
         OP_SHR: begin
            c      = acc[0];
            res    = {1'b0, acc[DATA_W-1:1]};
            wr_acc = 1'b1;
            wr_c   = 1'b1;
         end
         OP_HLT: halt    = 1'b1;
         OP_ILL: illegal = 1'b1;
         default: ;
      endcase
   end

   assign z = (res == '0);

endmodule

// File: rtl/acc_datapath.sv
// Accumulator datapath: edge-qualified control strobes drive
// PC/IR/MDR/OPR/ACC updates against a synchronous memory.
module acc_datapath #(
   parameter int DATA_W = acc_pkg::DATA_W_DEF,
   parameter int ADDR_W = acc_pkg::ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MRd,
   input  logic              ld_pc,
   input  logic              Inc_pc,
   input  logic              ld_IR,
   input  logic              Ld_acc,
   input  logic              ALU_setup,
   input  logic              Mwr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] acc,
   output logic              flag_z,
   output logic              flag_c,
   output logic              halted,
   output logic              illegal_op,
   output logic              strobe_err
);
   import acc_pkg::*;

   logic [6:0]        stb;
   logic [6:0]        stb_q;
   logic [6:0]        fire;
   logic              multi;
   logic              f_mrd, f_ldpc, f_inc, f_ldir;
   logic              f_ldacc, f_alu, f_mwr;
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] ir_addr;
   logic              take_br;
   logic [DATA_W-1:0] mdr;
   logic [DATA_W-1:0] opr;
   logic [DATA_W-1:0] opnd;
   pend_t             pend;

   logic [DATA_W-1:0] alu_res;
   logic              alu_c, alu_z;
   logic              alu_wr_acc, alu_wr_c;
   logic              alu_halt, alu_ill;

   assign stb = {Mwr, ALU_setup, Ld_acc, ld_IR,
                 Inc_pc, ld_pc, MRd};

   // Only the first high cycle of a strobe counts.
   assign fire  = stb & ~stb_q & {7{~halted}};
   assign multi = |(fire & (fire - 7'd1));

   assign f_mrd   = fire[0] & ~multi;
   assign f_ldpc  = fire[1] & ~multi;
   assign f_inc   = fire[2] & ~multi;
   assign f_ldir  = fire[3] & ~multi;
   assign f_ldacc = fire[4] & ~multi;
   assign f_alu   = fire[5] & ~multi;
   assign f_mwr   = fire[6] & ~multi;

   assign opcode  = ir[DATA_W-1 -: 4];
   assign ir_addr = ir[ADDR_W-1:0];

   assign take_br = (opcode == OP_JMP)
                  | ((opcode == OP_JZ) & flag_z)
                  | ((opcode == OP_JC) & flag_c);

   assign mem_rd    = f_mrd | f_ldacc;
   assign mem_wr    = f_mwr & (opcode == OP_STA);
   assign mem_addr  = (f_ldacc | mem_wr) ? ir_addr : pc;
   assign mem_wdata = acc;

   // Operand arriving this cycle bypasses OPR.
   assign opnd = (pend == PEND_OPR) ? mem_rdata : opr;

   acc_alu #(.DATA_W(DATA_W)) u_alu (
      .op      (opcode),
      .acc     (acc),
      .opnd    (opnd),
      .res     (alu_res),
      .c       (alu_c),
      .z       (alu_z),
      .wr_acc  (alu_wr_acc),
      .wr_c    (alu_wr_c),
      .halt    (alu_halt),
      .illegal (alu_ill)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         stb_q      <= '0;
         pc         <= '0;
         ir         <= '0;
         mdr        <= '0;
         opr        <= '0;
         acc        <= '0;
         flag_z     <= 1'b0;
         flag_c     <= 1'b0;
         halted     <= 1'b0;
         pend       <= PEND_NONE;
         illegal_op <= 1'b0;
         strobe_err <= 1'b0;
      end else begin
         stb_q      <= stb;
         strobe_err <= multi;
         illegal_op <= f_alu & alu_ill;

         case (pend)
            PEND_MDR: mdr <= mem_rdata;
            PEND_OPR: opr <= mem_rdata;
            default: ;
         endcase

         if (f_mrd)
            pend <= PEND_MDR;
         else if (f_ldacc)
            pend <= PEND_OPR;
         else
            pend <= PEND_NONE;

         if (f_ldpc && take_br)
            pc <= ir_addr;
         if (f_inc)
            pc <= pc + ADDR_W'(1);
         if (f_ldir)
            ir <= mdr;

         if (f_alu) begin
            if (alu_wr_acc) begin
               acc    <= alu_res;
               flag_z <= alu_z;
            end
            if (alu_wr_c)
               flag_c <= alu_c;
            if (alu_halt)
               halted <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_acc_datapath.sv
// Directed bench for acc_datapath: ALU vector table plus
// hand sequences for strobes, branches, errors and halt.
module tb_acc_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  stb;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [31:0] mem_rdata;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [7:0]  pc;
   logic [31:0] ir;
   logic [31:0] acc;
   logic        flag_z, flag_c, halted;
   logic        illegal_op, strobe_err;

   logic [31:0] tbmem [256];
   int rd_cnt = 0;
   int wr_cnt = 0;
   int err_cnt = 0;
   int ill_cnt = 0;
   logic [7:0]  last_waddr = '0;
   logic [31:0] last_wdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   acc_datapath dut (
      .clk        (clk),
      .rst        (rst),
      .MRd        (stb[0]),
      .ld_pc      (stb[1]),
      .Inc_pc     (stb[2]),
      .ld_IR      (stb[3]),
      .Ld_acc     (stb[4]),
      .ALU_setup  (stb[5]),
      .Mwr        (stb[6]),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_rdata  (mem_rdata),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata),
      .pc         (pc),
      .ir         (ir),
      .acc        (acc),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .halted     (halted),
      .illegal_op (illegal_op),
      .strobe_err (strobe_err)
   );

   // Synchronous memory model and pulse counters.
   always @(posedge clk) begin
      if (mem_rd) begin
         mem_rdata <= tbmem[mem_addr];
         rd_cnt    <= rd_cnt + 1;
      end
      if (mem_wr) begin
         wr_cnt     <= wr_cnt + 1;
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
      end
      if (strobe_err) err_cnt <= err_cnt + 1;
      if (illegal_op) ill_cnt <= ill_cnt + 1;
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [6:0] s);
      stb = s;
      @(posedge clk);
      #1;
   endtask

   task automatic instr();
      for (int k = 0; k < 7; k++)
         step(7'(1 << k));
      step(7'd0);
   endtask

   task automatic do_reset();
      for (int k = 0; k < 256; k++)
         tbmem[k] = '0;
      rst = 1'b1;
      step(7'd0);
      step(7'd0);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] acc;
      logic        c;
      logic        z;
   } vec_t;

   vec_t v[14];
   int w0, e0, i0, r0;

   initial begin
      rst = 1'b1;
      stb = '0;
      mem_rdata = '0;

      v[0]  = '{4'h2, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b1};
      v[1]  = '{4'h2, 32'h5, 32'h7, 32'hC, 1'b0, 1'b0};
      v[2]  = '{4'h3, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      v[3]  = '{4'h3, 32'h7, 32'h3, 32'h4, 1'b0, 1'b0};
      v[4]  = '{4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00,
                32'hF000_F000, 1'b0, 1'b0};
      v[5]  = '{4'h5, 32'h0F0, 32'h00F, 32'h0FF, 1'b0, 1'b0};
      v[6]  = '{4'h6, 32'hAAAA_5555, 32'hAAAA_5555,
                32'h0, 1'b0, 1'b1};
      v[7]  = '{4'h7, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b0, 1'b0};
      v[8]  = '{4'h7, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b1};
      v[9]  = '{4'h8, 32'h8000_0001, 32'h0, 32'h2, 1'b1, 1'b0};
      v[10] = '{4'h9, 32'h3, 32'h0, 32'h1, 1'b1, 1'b0};
      v[11] = '{4'h9, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1};
      v[12] = '{4'h1, 32'h55, 32'h0, 32'h0, 1'b0, 1'b1};
      v[13] = '{4'h0, 32'h1234, 32'h99, 32'h1234, 1'b0, 1'b0};

      @(posedge clk);
      #1;

      // Reset state and first LDA sequence
      do_reset();
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_acc", acc, 32'h0);
      chk("rst_ir", ir, 32'h0);
      chk("rst_bits",
          32'({flag_z, flag_c, halted, mem_rd,
               mem_wr, strobe_err, illegal_op}), 32'h0);
      tbmem[0] = 32'h1000_0005;
      tbmem[5] = 32'h0000_002A;
      instr();
      chk("lda_ir", ir, 32'h1000_0005);
      chk("lda_acc", acc, 32'h2A);
      chk("lda_pc", 32'(pc), 32'h1);
      chk("lda_z", 32'(flag_z), 32'h0);

      // ALU vector table
      for (int i = 0; i < 14; i++) begin
         do_reset();
         tbmem[0]     = 32'h1000_0010;
         tbmem[8'h10] = v[i].a;
         tbmem[1]     = {v[i].op, 20'h0, 8'h11};
         tbmem[8'h11] = v[i].b;
         instr();
         instr();
         chk($sformatf("vec%0d_acc", i), acc, v[i].acc);
         chk($sformatf("vec%0d_cz", i),
             32'({flag_c, flag_z}), 32'({v[i].c, v[i].z}));
      end

      // ADD carry, SUB borrow, then AND keeps C
      do_reset();
      tbmem[0] = 32'h1000_0010;
      tbmem[1] = 32'h2000_0011;
      tbmem[2] = 32'h3000_0011;
      tbmem[3] = 32'h4000_0010;
      tbmem[8'h10] = 32'hFFFF_FFFF;
      tbmem[8'h11] = 32'h1;
      instr();
      instr();
      chk("add_acc", acc, 32'h0);
      chk("add_cz", 32'({flag_c, flag_z}), 32'h3);
      instr();
      chk("sub_acc", acc, 32'hFFFF_FFFF);
      chk("sub_cz", 32'({flag_c, flag_z}), 32'h2);
      instr();
      chk("and_keep_c", 32'({flag_c, flag_z}), 32'h2);

      // STA with Mwr held two cycles
      do_reset();
      tbmem[0] = 32'h1000_0010;
      tbmem[1] = 32'hA000_0040;
      tbmem[8'h10] = 32'h1234;
      w0 = wr_cnt;
      instr();
      for (int k = 0; k < 6; k++)
         step(7'(1 << k));
      stb = 7'h40;
      #2;
      chk("sta_wr", 32'(mem_wr), 32'h1);
      chk("sta_addr", 32'(mem_addr), 32'h40);
      chk("sta_wdata", mem_wdata, 32'h1234);
      @(posedge clk);
      #3;
      chk("sta_hold_wr", 32'(mem_wr), 32'h0);
      @(posedge clk);
      #1;
      step(7'd0);
      chk("sta_cnt", 32'(wr_cnt - w0), 32'h1);
      chk("sta_laddr", 32'(last_waddr), 32'h40);
      chk("sta_ldata", last_wdata, 32'h1234);

      // JZ not taken with Z=0
      do_reset();
      tbmem[0] = 32'hC000_0080;
      instr();
      instr();
      chk("jz_nt_pc", 32'(pc), 32'h2);

      // JZ taken with Z=1
      do_reset();
      tbmem[0] = 32'h1000_0010;
      tbmem[1] = 32'hC000_0080;
      instr();
      instr();
      instr();
      chk("jz_t_pc", 32'(pc), 32'h81);

      // JMP to 0xFF then Inc_pc wraps
      do_reset();
      tbmem[0] = 32'hB000_00FF;
      instr();
      instr();
      chk("pc_wrap", 32'(pc), 32'h0);

      // Two strobes in one cycle
      do_reset();
      tbmem[0] = 32'h1000_0010;
      tbmem[8'h10] = 32'h33;
      instr();
      e0 = err_cnt;
      r0 = rd_cnt;
      stb = 7'b000_0101;
      #2;
      chk("multi_rd", 32'(mem_rd), 32'h0);
      @(posedge clk);
      #1;
      chk("multi_pc", 32'(pc), 32'h1);
      step(7'd0);
      step(7'd0);
      chk("multi_err", 32'(err_cnt - e0), 32'h1);
      chk("multi_nord", 32'(rd_cnt - r0), 32'h0);

      // Illegal opcode
      do_reset();
      tbmem[0] = 32'h1000_0010;
      tbmem[1] = 32'hE000_0011;
      tbmem[8'h10] = 32'h77;
      tbmem[8'h11] = 32'h5;
      i0 = ill_cnt;
      instr();
      instr();
      chk("ill_acc", acc, 32'h77);
      chk("ill_cnt", 32'(ill_cnt - i0), 32'h1);

      // HLT freezes everything
      do_reset();
      tbmem[0] = 32'h1000_0010;
      tbmem[1] = 32'hF000_0000;
      tbmem[2] = 32'h1000_0011;
      tbmem[8'h10] = 32'h99;
      tbmem[8'h11] = 32'h11;
      instr();
      instr();
      chk("hlt_flag", 32'(halted), 32'h1);
      r0 = rd_cnt;
      w0 = wr_cnt;
      instr();
      chk("hlt_pc", 32'(pc), 32'h2);
      chk("hlt_acc", acc, 32'h99);
      chk("hlt_mem",
          32'((rd_cnt - r0) + (wr_cnt - w0)), 32'h0);

      // Reset between Ld_acc and ALU_setup drops capture
      do_reset();
      tbmem[0] = 32'h1000_0010;
      tbmem[8'h10] = 32'h5A;
      for (int k = 0; k < 5; k++)
         step(7'(1 << k));
      rst = 1'b1;
      step(7'd0);
      rst = 1'b0;
      chk("mid_pc", 32'(pc), 32'h0);
      chk("mid_ir", ir, 32'h0);
      chk("mid_halt", 32'(halted), 32'h0);
      for (int k = 0; k < 4; k++)
         step(7'(1 << k));
      step(7'h20);
      step(7'd0);
      chk("mid_opr", acc, 32'h0);
      chk("mid_z", 32'(flag_z), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acc_datapath.md
# acc_datapath

Accumulator datapath driven by the control-strobe sequencer (`MRd`, `ld_pc`, `Inc_pc`, `ld_IR`, `Ld_acc`, `ALU_setup`, `Mwr`). It holds PC, MDR, IR, operand register OPR, ACC and flags. It executes each strobe's micro-operation against a synchronous single-port memory. It sits directly downstream of the sequencer and upstream of program/data memory.

## Interface
- `DATA_W`, 32: word width of ACC, IR, MDR, OPR and the memory data bus.
- `ADDR_W`, 8: PC and memory address width. The IR address field is `IR[ADDR_W-1:0]`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `MRd`, `ld_pc`, `Inc_pc`, `ld_IR`, `Ld_acc`, `ALU_setup`, `Mwr` in 1 each: control strobes from the sequencer.
- `mem_addr` out ADDR_W: memory address (combinational mux).
- `mem_rd` out 1: memory read enable. Read data is valid one cycle later.
- `mem_rdata` in DATA_W: memory read data.
- `mem_wr` out 1: memory write enable.
- `mem_wdata` out DATA_W: memory write data. Always equals ACC.
- `pc` out ADDR_W, `ir` out DATA_W, `acc` out DATA_W: architectural state.
- `flag_z`, `flag_c` out 1: zero flag and carry/borrow flag.
- `halted` out 1: HLT has executed.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.
- `strobe_err` out 1: one-cycle pulse when more than one strobe fires.

## Operation
- **Edge qualification.** Each strobe acts only in its first high cycle: `fire_x = x & ~x_q`, where `x_q` is that strobe's value registered from the previous cycle. The sequencer can hold a strobe high for two cycles, and the second cycle must be ignored.
- **Multiple strobes.** If two or more `fire_*` are high in the same cycle, no state is updated and `strobe_err` pulses.
- **Halted.** While `halted` is set, all fires are ignored and `mem_rd`/`mem_wr` stay 0.
- **Opcode** is `IR[DATA_W-1:DATA_W-4]`: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 SHL, 9 SHR, A STA, B JMP, C JZ, D JC, F HLT. E is illegal.
- **fire_MRd.** `mem_addr = pc`, `mem_rd = 1`. Set `rd_pend = MDR`.
- **fire_ld_pc.** If opcode is JMP, or JZ with Z=1, or JC with C=1: PC <= IR addr field. Otherwise PC is unchanged.
- **fire_Inc_pc.** PC <= PC+1, wrapping modulo 2^ADDR_W (0xFF -> 0x00).
- **fire_ld_IR.** IR <= MDR.
- **fire_Ld_acc.** `mem_addr` = IR addr field, `mem_rd = 1`. Set `rd_pend = OPR`.
- **Read capture.** In the cycle after a read fire, `mem_rdata` is written into the pending target (MDR or OPR) and `rd_pend` clears.
- **fire_ALU_setup.**
  - Operand is `mem_rdata` if `rd_pend == OPR` this cycle (bypass); otherwise it is OPR.
  - ADD: {C,ACC} <= ACC+op (DATA_W+1-bit sum).
  - SUB: ACC <= ACC-op, C = borrow (ACC < op, unsigned).
  - AND/OR/XOR: bitwise with op. NOT: ~ACC. LDA: ACC <= op.
  - SHL: C <= ACC[MSB], ACC <<= 1. SHR: C <= ACC[0], ACC >>= 1.
  - Z <= (new ACC == 0) for every op that writes ACC. C is unchanged except on ADD, SUB, SHL and SHR.
  - HLT sets `halted`. Illegal opcode pulses `illegal_op`, and ACC/flags are unchanged.
  - NOP, STA and branch opcodes change nothing here.
- **fire_Mwr.** Only when opcode is STA: `mem_addr` = IR addr field, `mem_wr = 1`. Otherwise no write.
- **Default address.** When no memory access is active, `mem_addr = pc`.

## Timing
- **Reset:**
  - PC, IR, MDR, OPR, ACC all 0.
  - Z, C, `halted` 0.
  - `rd_pend` = none.
  - All `x_q` 0.
  - `mem_rd`, `mem_wr`, `illegal_op`, `strobe_err` all 0.
  - Reset issued mid-read drops the pending capture.
- **Update timing.** Every register update happens at the rising edge ending the fire cycle. Read data lands one edge later.
- **Combinational outputs.** `mem_rd`/`mem_wr`/`mem_addr` are combinational from `fire_*`, with zero latency, and are high for exactly one cycle per fire.
- **Sequencer order.**
  - MRd (t1), ld_pc (t2), Inc_pc (t3), ld_IR (t4), Ld_acc (t5), ALU_setup (t6), Mwr (t7).
  - MDR is valid at the end of t2. OPR is bypassed at t6.
- **Read during pending capture.** A read fire that coincides with a pending capture is legal: the capture completes and the new pend replaces it.

## Structure
- Shared package `acc_pkg`: opcode localparams, the `rd_pend` encoding (NONE/MDR/OPR), and the DATA_W/ADDR_W defaults.
- One natural sub-module, `acc_alu`: combinational op/ACC/operand -> result, C, Z.
- Strobe edge detect, registers and memory mux live in the top module.

## Test plan
- **Reset.** Reset, then memory[0]=0x1000_0005 (LDA 5), memory[5]=0x0000_002A, run one sequence. Expect: IR=0x1000_0005, ACC=0x2A, PC=1, Z=0.
- **ADD carry.** ACC=0xFFFF_FFFF, ADD of operand 1. Expect: ACC=0, C=1, Z=1. Then SUB of operand 1: ACC=0xFFFF_FFFF, C=1 (borrow).
- **STA.** STA 0x40 with ACC=0x1234. Expect: exactly one `mem_wr` pulse at the Mwr fire, addr=0x40, wdata=0x1234, even with `Mwr` held high two cycles.
- **Branches.** JZ 0x80 with Z=1 gives PC=0x81 after Inc_pc. With Z=0, PC advances by one. PC=0xFF followed by Inc_pc gives 0x00.
- **Errors.** `MRd` and `Inc_pc` high together: PC unchanged, no `mem_rd`, `strobe_err` pulses once. Opcode 0xE at ALU_setup: `illegal_op` pulses, ACC unchanged.
- **HLT.** After HLT, further sequences leave PC/ACC unchanged with no memory activity. `rst` asserted between the Ld_acc fire and ALU_setup clears all state, and OPR stays 0.
